itu656_decoder: RTL
===================

// Module: itu656_decoder
// PURPOSE
//  Decodes the ITU-R BT.656 10-bit YCrCb stream from the ADV7185 video input.
//  It runs in the clk_54mhz domain and is qualified by the 27 MHz enable strobe
//  from clock_divider: a one-cycle pulse every second clk_54mhz cycle.
//  - Finds SAV/EAV timing codes and tracks the F/V/H flags.
//  - Emits 4:4:4 Y/Cr/Cb pixels plus an x coordinate to the key-detection pipeline.
// PARAMETERS
//  DATA_W        10  width of the video data bus (BT.656 10-bit words)
//  X_W           11  width of the x_count pixel-column counter
//  PARITY_CHECK  1   1 = discard timing codes whose P3..P0 mismatch; 0 = accept all
// PORTS
//  clk_54mhz    in   1         system clock; all logic on rising edge
//  restart      in   1         asynchronous, active-high reset
//  en           in   1         27 MHz sample strobe; din is sampled only when en=1
//  din          in   DATA_W    BT.656 word (tv_in_ycrcb[19:10])
//  f            out  1         field flag from the last valid timing code
//  v            out  1         vertical-blank flag from the last valid timing code
//  h            out  1         1 = after EAV (horizontal blank), 0 = after SAV
//  sav_pulse    out  1         1-cycle pulse: valid SAV accepted
//  eav_pulse    out  1         1-cycle pulse: valid EAV accepted
//  code_err     out  1         1-cycle pulse: XYZ parity mismatch (PARITY_CHECK=1 only)
//  pix_valid    out  1         1-cycle pulse: y/cr/cb/x_count hold a new pixel
//  y,cr,cb      out  DATA_W    pixel components, held between pix_valid pulses
//  x_count      out  X_W       column index of the current pixel, 0 = first after SAV
// BEHAVIOUR
//  Reset
//  - restart=1 clears all regs asynchronously.
//  - f=0, v=1, h=1; all pulses 0; y/cr/cb=0; x_count=0; FSM=SEARCH; phase=0.
//  - en is ignored while restart=1.
//  Enable
//  - All state advances only on cycles with en=1.
//  - Outputs register on that same edge, so pulses are visible the cycle after the en cycle.
//  - Pulses are always exactly 1 clk_54mhz wide.
//  Preamble FSM (evaluated on every en, including during active video):
//  - SEARCH: din==3FF -> P1.
//  - P1: din==000 -> P2; din==3FF -> P1; else -> SEARCH.
//  - P2: din==000 -> P3; din==3FF -> P1; else -> SEARCH.
//  - P3: din is XYZ -> SEARCH.
//  XYZ decode
//  - Fields: bit9=1, F=bit8, V=bit7, H=bit6, P3..P0=bits5..2.
//  - Expected parity: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
//  - Code is valid iff bit9=1 and (PARITY_CHECK=0 or parity matches).
//  - Valid code: latch f/v/h; pulse sav_pulse if H=0, else eav_pulse.
//  - Invalid code: flags unchanged, code_err pulses, no sav/eav pulse.
//  Active video
//  - Active iff h=0 and v=0.
//  - A valid SAV sets phase=0 and x_count=0.
//  - Each following en word while active (and FSM in SEARCH) cycles phase 0..3 = Cb, Y0, Cr, Y1.
//  - Cb and Y0 are latched internally.
//  - Cr phase: y=Y0, cr=Cr, cb=Cb, pix_valid=1.
//  - Y1 phase: y=Y1 (cr/cb unchanged), pix_valid=1.
//  - x_count increments after every pix_valid. It saturates at 2^X_W-1 and does not wrap.
//  - Latency: pixel appears 1 clk_54mhz after the en cycle carrying Cr (or Y1).
//  Boundaries
//  - Words consumed by the preamble FSM (P1..P3 path) are never treated as pixel data.
//  - A preamble arriving mid-quad abandons the partial quad; no pix_valid is issued.
//  - EAV ends active video immediately; phase is held until the next SAV.
//  - No pix_valid while v=1 or h=1.
//  - restart mid-line drops the partial quad; output resumes only after the next valid SAV.
// STRUCTURE
//  video_defs.vh (shared include):
//  - SYNC_FF=10'h3FF, SYNC_00=10'h000.
//  - FSM state encodings SEARCH/P1/P2/P3.
//  - Phase encodings PH_CB/PH_Y0/PH_CR/PH_Y1.
//  Sub-module bt656_xyz_check (combinational): din -> f, v, h, valid.
//  The FSM, phase counter and pixel registers stay in the top module.
// TESTING
//  1. Async restart mid-stream (no clk edge)
//     -> outputs reset immediately: v=1, h=1, pix_valid=0, x_count=0.
//  2. en stream 3FF,000,000,200 (F0 V0 H0 SAV), then 040,100,080,104
//     -> sav_pulse; pix (y=100,cr=080,cb=040) x=0; pix (y=104) x=1.
//  3. 3FF,000,000,274 (F0 V0 H1 EAV) during active video
//     -> eav_pulse, h=1, no further pix_valid until next SAV.
//  4. XYZ=204 (parity wrong) with PARITY_CHECK=1
//     -> code_err pulse, f/v/h unchanged; with PARITY_CHECK=0 -> accepted as SAV.
//  5. 3FF,3FF,000,000,200 -> single sav_pulse; en held low 5 cycles mid-quad
//     -> no state change, no pulse.
//  6. SAV followed by 2^X_W+2 pixels -> x_count stops at 2^X_W-1; a 3FF,000,000,... preamble
//     mid-quad -> partial quad dropped.

Source files
------------

// File: rtl/itu656_decoder_pkg.sv
// Shared constants and encodings for the BT.656 decoder: sync words,
// preamble-search states and the 4:2:2 quad phase.
package itu656_decoder_pkg;

   localparam logic [9:0] SYNC_FF = 10'h3FF;
   localparam logic [9:0] SYNC_00 = 10'h000;

   typedef enum logic [1:0] {SEARCH, P1, P2, P3} pre_state_t;

   typedef enum logic [1:0] {PH_CB, PH_Y0, PH_CR, PH_Y1} phase_t;

endpackage

// File: rtl/itu656_decoder_xyz_check.sv
// Combinational decode of a BT.656 XYZ timing word (top 8 bits):
// F/V/H flags, protection-bit check and validity.
module itu656_decoder_xyz_check #(
   parameter bit PARITY_CHECK = 1'b1
) (
   input  logic [7:0] xyz,
   output logic       f,
   output logic       v,
   output logic       h,
   output logic       valid,
   output logic       par_err
);

   logic [3:0] par_exp;
   logic       par_ok;

   assign f       = xyz[6];
   assign v       = xyz[5];
   assign h       = xyz[4];
   assign par_exp = {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
   assign par_ok  = (xyz[3:0] == par_exp);
   assign valid   = xyz[7] && (!PARITY_CHECK || par_ok);
   // With checking disabled nothing is flagged, even a word lacking the marker bit.
   assign par_err = PARITY_CHECK ? !valid : 1'b0;

endmodule

// File: rtl/itu656_decoder.sv
// BT.656 10-bit stream decoder: finds SAV/EAV, tracks F/V/H and expands
// Cb Y0 Cr Y1 quads into 4:4:4 pixels with a column index.
module itu656_decoder
   import itu656_decoder_pkg::*;
#(
   parameter int DATA_W       = 10,
   parameter int X_W          = 11,
   parameter bit PARITY_CHECK = 1'b1
) (
   input  logic              clk_54mhz,
   input  logic              restart,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic              f,
   output logic              v,
   output logic              h,
   output logic              sav_pulse,
   output logic              eav_pulse,
   output logic              code_err,
   output logic              pix_valid,
   output logic [DATA_W-1:0] y,
   output logic [DATA_W-1:0] cr,
   output logic [DATA_W-1:0] cb,
   output logic [X_W-1:0]    x_count
);

   pre_state_t        state, state_nx;
   phase_t            phase;
   logic [DATA_W-1:0] cb_lat, y0_lat;
   logic [X_W-1:0]    x_next;
   logic              code_word, sync_start, pix_word;
   logic              xf, xv, xh, xvalid, xerr;

   itu656_decoder_xyz_check #(.PARITY_CHECK(PARITY_CHECK)) u_xyz (
      .xyz     (din[DATA_W-1 -: 8]),
      .f       (xf),
      .v       (xv),
      .h       (xh),
      .valid   (xvalid),
      .par_err (xerr)
   );

   always_ff @(posedge clk_54mhz or posedge restart) begin
      if (restart) state <= SEARCH;
      else         state <= state_nx;
   end

   // Preamble search runs on every sample, so a sync sequence always wins over pixel data.
   always_comb begin
      state_nx   = state;
      code_word  = 1'b0;
      sync_start = 1'b0;
      pix_word   = 1'b0;
      if (en) begin
         case (state)
            SEARCH: begin
               if (din == SYNC_FF) begin
                  state_nx   = P1;
                  sync_start = 1'b1;
               end else begin
                  pix_word = !h && !v;
               end
            end
            P1, P2: begin
               if (din == SYNC_00)      state_nx = (state == P1) ? P2 : P3;
               else if (din == SYNC_FF) state_nx = P1;
               else                     state_nx = SEARCH;
            end
            default: begin
               state_nx  = SEARCH;
               code_word = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_54mhz or posedge restart) begin
      if (restart) begin
         f         <= 1'b0;
         v         <= 1'b1;
         h         <= 1'b1;
         sav_pulse <= 1'b0;
         eav_pulse <= 1'b0;
         code_err  <= 1'b0;
         pix_valid <= 1'b0;
         y         <= '0;
         cr        <= '0;
         cb        <= '0;
         cb_lat    <= '0;
         y0_lat    <= '0;
         x_count   <= '0;
         x_next    <= '0;
         phase     <= PH_CB;
      end else begin
         sav_pulse <= 1'b0;
         eav_pulse <= 1'b0;
         code_err  <= 1'b0;
         pix_valid <= 1'b0;
         if (code_word) begin
            if (xvalid) begin
               f <= xf;
               v <= xv;
               h <= xh;
               if (xh) begin
                  eav_pulse <= 1'b1;
               end else begin
                  sav_pulse <= 1'b1;
                  phase     <= PH_CB;
                  x_count   <= '0;
                  x_next    <= '0;
               end
            end else begin
               code_err <= xerr;
            end
         end else if (sync_start) begin
            // A sync word mid-quad abandons whatever partial quad was collected.
            phase <= PH_CB;
         end else if (pix_word) begin
            phase <= phase_t'(phase + 2'd1);
            case (phase)
               PH_CB: cb_lat <= din;
               PH_Y0: y0_lat <= din;
               PH_CR: begin
                  y         <= y0_lat;
                  cr        <= din;
                  cb        <= cb_lat;
                  pix_valid <= 1'b1;
                  x_count   <= x_next;
                  x_next    <= (x_next == '1) ? x_next : x_next + 1'b1;
               end
               default: begin
                  y         <= din;
                  pix_valid <= 1'b1;
                  x_count   <= x_next;
                  x_next    <= (x_next == '1) ? x_next : x_next + 1'b1;
               end
            endcase
         end
      end
   end

endmodule
